// File: rtl/hana_i2c_rx.sv
// hana_i2c_rx: write-only I2C target. Filters SCL/SDA, detects START/STOP, ACKs
// frames addressed to DEV_ADDR and strobes out every received data byte.
module hana_i2c_rx #(
    parameter logic [6:0] DEV_ADDR  = 7'h70,
    parameter int         FILT_LEN  = 3,
    parameter int         MAX_BYTES = 15
) (
    input  logic       clk_48m,
    input  logic       rst,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       frame_done,
    output logic [3:0] frame_len,
    output logic       bus_busy
);
    localparam logic [2:0] FILT_LAST = 3'(FILT_LEN - 1);
    localparam logic [3:0] MAX_CNT   = 4'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE} state_t;
    state_t state, state_next;

    logic [1:0] scl_sync, sda_sync;
    logic [2:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_d, sda_d;
    logic       scl_rise, scl_fall, start, stop, byte_done, addr_ok;
    logic [6:0] shift;
    logic [7:0] byte_in;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic       matched, first, ack_en, ack_phase, ack_drive;

    always_ff @(posedge clk_48m) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl_in};
            sda_sync <= {sda_sync[0], i2c_sda_in};
            scl_d    <= scl_f;
            sda_d    <= sda_f;
        end
    end

    // A filtered level only follows the synchronized pad after FILT_LEN
    // consecutive disagreeing samples.
    always_ff @(posedge clk_48m) begin
        if (rst) begin
            scl_f   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
        end else if (scl_cnt == FILT_LAST) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_48m) begin
        if (rst) begin
            sda_f   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
        end else if (sda_cnt == FILT_LAST) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + 3'd1;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start     = scl_f & sda_d & ~sda_f;
    assign stop      = scl_f & ~sda_d & sda_f;
    assign byte_in   = {shift, sda_f};
    assign byte_done = scl_rise && (bit_cnt == 3'd7);
    assign addr_ok   = (byte_in[7:1] == DEV_ADDR) && !byte_in[0];

    always_ff @(posedge clk_48m) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ADDR;
        end else if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                ADDR:         if (byte_done) state_next = addr_ok ? ACK_A : IGNORE;
                DATA:         if (byte_done) state_next = ACK_D;
                ACK_A, ACK_D: if (scl_fall && ack_phase) state_next = DATA;
                default:      state_next = state;
            endcase
        end
    end

    // START/STOP take priority over any SCL edge seen in the same cycle.
    always_ff @(posedge clk_48m) begin
        if (rst) begin
            shift      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            matched    <= 1'b0;
            first      <= 1'b0;
            ack_en     <= 1'b0;
            ack_phase  <= 1'b0;
            ack_drive  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            bus_busy   <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            frame_done <= 1'b0;
            if (start) begin
                bus_busy  <= 1'b1;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                matched   <= 1'b0;
                first     <= 1'b0;
                ack_phase <= 1'b0;
                ack_drive <= 1'b0;
            end else if (stop) begin
                bus_busy   <= 1'b0;
                bit_cnt    <= '0;
                ack_phase  <= 1'b0;
                ack_drive  <= 1'b0;
                matched    <= 1'b0;
                frame_done <= matched;
                if (matched) frame_len <= byte_cnt;
            end else begin
                if (scl_rise && (state == ADDR || state == DATA)) begin
                    shift   <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done && state == ADDR && addr_ok) begin
                    matched <= 1'b1;
                    first   <= 1'b1;
                    ack_en  <= 1'b1;
                end
                if (byte_done && state == DATA) begin
                    rx_data  <= byte_in;
                    rx_valid <= 1'b1;
                    rx_first <= first;
                    first    <= 1'b0;
                    ack_en   <= (byte_cnt < MAX_CNT);
                    if (byte_cnt < MAX_CNT) byte_cnt <= byte_cnt + 4'd1;
                end
                // First SCL fall of the slot starts driving, the second ends it.
                if (scl_fall && (state == ACK_A || state == ACK_D)) begin
                    ack_phase <= ~ack_phase;
                    ack_drive <= ~ack_phase & ack_en;
                end
            end
        end
    end

    always_comb begin
        i2c_sda_oe = ack_drive;
        if (rst || start || stop) i2c_sda_oe = 1'b0;
    end
endmodule

// File: tb/tb_hana_i2c_rx.sv
// Bench for hana_i2c_rx: bit-banged I2C master on an open-drain SDA line,
// with a scoreboard checking every rx_valid and frame_done strobe.
`timescale 1ns/1ps
module tb_hana_i2c_rx;
    localparam int Q = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } rx_exp_t;

    logic       clk_48m = 1'b0;
    logic       rst;
    logic       scl_drv, sda_drv;
    logic       sda_line;
    logic       i2c_sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, frame_done, bus_busy;
    logic [3:0] frame_len;

    int         asserts = 0;
    int         fails   = 0;
    rx_exp_t    rx_q[$];
    logic [3:0] frame_q[$];

    assign sda_line = sda_drv & ~i2c_sda_oe;

    hana_i2c_rx #(.DEV_ADDR(7'h70), .FILT_LEN(3), .MAX_BYTES(2)) dut (
        .clk_48m   (clk_48m),
        .rst       (rst),
        .i2c_scl_in(scl_drv),
        .i2c_sda_in(sda_line),
        .i2c_sda_oe(i2c_sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .frame_done(frame_done),
        .frame_len (frame_len),
        .bus_busy  (bus_busy)
    );

    always #10 clk_48m = ~clk_48m;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk_48m);
    endtask

    // Only one line changes per call so SCL and SDA never move together.
    task automatic applyStimulus(input logic scl, input logic sda, input int quarters);
        scl_drv = scl;
        sda_drv = sda;
        waitClk(quarters * Q);
    endtask

    task automatic i2cStart();
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
    endtask

    task automatic i2cRepStart();
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
    endtask

    task automatic i2cStop();
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 2);
    endtask

    task automatic sendBits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, b[i], 1);
            applyStimulus(1'b1, b[i], 2);
            applyStimulus(1'b0, b[i], 1);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic exp_ack, input string name);
        sendBits(b);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput(name, 32'(i2c_sda_oe), 32'(exp_ack));
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1);
    endtask

    task automatic expectRx(input logic [7:0] d, input logic f);
        rx_exp_t e;
        e.data  = d;
        e.first = f;
        rx_q.push_back(e);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput(name, 32'({i2c_sda_oe, rx_data, rx_valid, rx_first, frame_done, frame_len, bus_busy}), 32'd0);
    endtask

    // Scoreboard monitor: compares each strobe against the head of its queue.
    initial begin
        rx_exp_t e;
        forever begin
            @(negedge clk_48m);
            if (!rst && rx_valid) begin
                if (rx_q.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("[TB] FAIL rx_unexpected: got rx_data 0x%0h, expected no strobe", rx_data);
                end else begin
                    e = rx_q.pop_front();
                    checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                    checkOutput("rx_first", 32'(rx_first), 32'(e.first));
                end
            end
            if (!rst && frame_done) begin
                if (frame_q.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("[TB] FAIL frame_unexpected: got frame_done len %0d, expected no strobe", frame_len);
                end else begin
                    checkOutput("frame_len", 32'(frame_len), 32'(frame_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got no end of test, expected $finish before 2 ms");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst     = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        waitClk(3);
        checkResetOutputs("reset_state");
        rst = 1'b0;
        waitClk(4 * Q);

        $display("[TB] write frame");
        checkOutput("busy_before_start", 32'(bus_busy), 32'd0);
        i2cStart();
        checkOutput("busy_after_start", 32'(bus_busy), 32'd1);
        sendByte(8'hE0, 1'b1, "ack_addr_e0");
        expectRx(8'h10, 1'b1);
        sendByte(8'h10, 1'b1, "ack_data_10");
        expectRx(8'h55, 1'b0);
        sendByte(8'h55, 1'b1, "ack_data_55");
        checkOutput("busy_mid_frame", 32'(bus_busy), 32'd1);
        frame_q.push_back(4'd2);
        i2cStop();
        checkOutput("busy_after_stop", 32'(bus_busy), 32'd0);
        checkOutput("frame_len_held", 32'(frame_len), 32'd2);

        $display("[TB] address mismatch");
        i2cStart();
        sendByte(8'hE2, 1'b0, "nak_addr_e2");
        sendByte(8'h10, 1'b0, "nak_ignored_data");
        i2cStop();

        $display("[TB] read request");
        i2cStart();
        sendByte(8'hE1, 1'b0, "nak_read_e1");
        i2cStop();
        checkOutput("busy_after_read", 32'(bus_busy), 32'd0);

        $display("[TB] repeated start");
        i2cStart();
        sendByte(8'hE0, 1'b1, "ack_addr_sr1");
        expectRx(8'h01, 1'b1);
        sendByte(8'h01, 1'b1, "ack_data_01");
        i2cRepStart();
        checkOutput("busy_after_sr", 32'(bus_busy), 32'd1);
        sendByte(8'hE0, 1'b1, "ack_addr_sr2");
        expectRx(8'h02, 1'b1);
        sendByte(8'h02, 1'b1, "ack_data_02");
        expectRx(8'h03, 1'b0);
        sendByte(8'h03, 1'b1, "ack_data_03");
        frame_q.push_back(4'd2);
        i2cStop();

        $display("[TB] overflow");
        i2cStart();
        sendByte(8'hE0, 1'b1, "ack_addr_ovf");
        expectRx(8'hAA, 1'b1);
        sendByte(8'hAA, 1'b1, "ack_data_aa");
        expectRx(8'hBB, 1'b0);
        sendByte(8'hBB, 1'b1, "ack_data_bb");
        expectRx(8'hCC, 1'b0);
        sendByte(8'hCC, 1'b0, "nak_data_cc");
        expectRx(8'hDD, 1'b0);
        sendByte(8'hDD, 1'b0, "nak_data_dd");
        frame_q.push_back(4'd2);
        i2cStop();

        $display("[TB] glitch and reset");
        applyStimulus(1'b1, 1'b1, 1);
        sda_drv = 1'b0;
        waitClk(1);
        sda_drv = 1'b1;
        waitClk(2 * Q);
        checkOutput("glitch_no_start", 32'(bus_busy), 32'd0);
        i2cStart();
        sendBits(8'hE0);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("ack_before_reset", 32'(i2c_sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("oe_released_by_rst", 32'(i2c_sda_oe), 32'd0);
        waitClk(1);
        checkResetOutputs("reset_mid_frame");
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 4);
        i2cStart();
        sendByte(8'hE0, 1'b1, "ack_addr_after_rst");
        expectRx(8'h5A, 1'b1);
        sendByte(8'h5A, 1'b1, "ack_data_5a");
        frame_q.push_back(4'd1);
        i2cStop();
        waitClk(4 * Q);

        checkOutput("rx_queue_left", 32'(rx_q.size()), 32'd0);
        checkOutput("frame_queue_left", 32'(frame_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
